aqe_axi_burst_master: RTL and testbench

AXI4 burst initiator that issues single-outstanding 128-bit read and write bursts onto the `_m1` master port of the on-chip SRAM subsystem. A local command/stream interface feeds it: a loader or test engine posts {direction, address, length} and streams write beats in or receives read beats out. It is the initiator counterpart of the SRAM's AXI slave port and drives its `ar/aw/w/r/b` channels directly.

---
 rtl/aqe_axi_burst_master.sv | 206 ++++++++++++++++++++
 tb/tb_aqe_axi_burst_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aqe_axi_burst_master.sv
// aqe_axi_burst_master
//   Single-outstanding AXI4 burst initiator for the SRAM subsystem _m1 port.
//   A local command {write, addr, len, wrap} launches one 128-bit burst.
//   Write beats stream in on wbeat_*, and read beats stream out on rbeat_*.
//   When the burst finishes, done pulses for one cycle. done_err flags a
//   non-OKAY response, an ID mismatch, or an rlast/beat-count disagreement.
//
// Ports
//   pll_core_cpuclk, pad_cpu_rst_b      : clock / async active-low reset
//   cmd_valid/ready/write/addr/len/wrap : burst command
//   wbeat_valid/ready/data/strb         : write data stream (into the master)
//   rbeat_valid/ready/data/last         : read data stream (out of the master)
//   done, done_err                      : completion pulse and status
//   ar*/aw*/w*/r*/b* _m1                : AXI4 master channels
//
// Configuration macro
//   AQE_AXI_BURST_MASTER_WRAP_EN : honour cmd_wrap for len 1 or 3 (WRAP burst).
//                                  When undefined, bursts are always INCR.
module aqe_axi_burst_master #(
  parameter logic [7:0] AXI_ID = 8'h0,
  parameter int         ADDR_W = 40
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              cmd_wrap,
  input  logic              wbeat_valid,
  output logic              wbeat_ready,
  input  logic [127:0]      wbeat_data,
  input  logic [15:0]       wbeat_strb,
  output logic              rbeat_valid,
  input  logic              rbeat_ready,
  output logic [127:0]      rbeat_data,
  output logic              rbeat_last,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] araddr_m1,
  output logic [7:0]        arlen_m1,
  output logic [2:0]        arsize_m1,
  output logic [1:0]        arburst_m1,
  output logic [3:0]        arcache_m1,
  output logic [2:0]        arprot_m1,
  output logic [7:0]        arid_m1,
  output logic              arvalid_m1,
  input  logic              arready_m1,
  output logic [ADDR_W-1:0] awaddr_m1,
  output logic [7:0]        awlen_m1,
  output logic [2:0]        awsize_m1,
  output logic [1:0]        awburst_m1,
  output logic [3:0]        awcache_m1,
  output logic [2:0]        awprot_m1,
  output logic [7:0]        awid_m1,
  output logic              awvalid_m1,
  input  logic              awready_m1,
  output logic [127:0]      wdata_m1,
  output logic [15:0]       wstrb_m1,
  output logic              wlast_m1,
  output logic [7:0]        wid_m1,
  output logic              wvalid_m1,
  input  logic              wready_m1,
  input  logic [127:0]      rdata_m1,
  input  logic [7:0]        rid_m1,
  input  logic [1:0]        rresp_m1,
  input  logic              rlast_m1,
  input  logic              rvalid_m1,
  output logic              rready_m1,
  input  logic [7:0]        bid_m1,
  input  logic [1:0]        bresp_m1,
  input  logic              bvalid_m1,
  output logic              bready_m1
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_AW, S_WR, S_BR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              done_q;
  logic              done_err_q;

  logic              last_beat;
  logic              rd_hs;
  logic              wr_hs;
  logic              rbeat_err;
  logic              b_err;
  logic [1:0]        burst_d;
  logic              unused_in;

  // WRAP is only legal for 2 and 4 beat bursts here. The slave does the
  // wrapping, so the start address is issued untouched.
`ifdef AQE_AXI_BURST_MASTER_WRAP_EN
  assign burst_d   = (cmd_wrap && (cmd_len == 8'd1 || cmd_len == 8'd3)) ? 2'b10 : 2'b01;
  assign unused_in = ^cmd_addr[3:0];
`else
  assign burst_d   = 2'b01;
  assign unused_in = ^{cmd_addr[3:0], cmd_wrap};
`endif

  assign last_beat = (cnt_q == len_q);
  assign rd_hs     = (state_q == S_RD) && rvalid_m1 && rbeat_ready;
  assign wr_hs     = (state_q == S_WR) && wbeat_valid && wready_m1;
  // The beat counter is authoritative; a disagreeing rlast only flags an error.
  assign rbeat_err = (rresp_m1 != 2'b00) || (rid_m1 != AXI_ID) || (rlast_m1 != last_beat);
  assign b_err     = (bresp_m1 != 2'b00) || (bid_m1 != AXI_ID);

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= 2'b01;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (cmd_valid) begin
            addr_q  <= {cmd_addr[ADDR_W-1:4], 4'h0};
            len_q   <= cmd_len;
            burst_q <= burst_d;
            err_q   <= 1'b0;
            state_q <= cmd_write ? S_AW : S_AR;
          end
        end
        S_AR: if (arready_m1) state_q <= S_RD;
        S_RD: begin
          if (rd_hs) begin
            err_q <= err_q | rbeat_err;
            if (last_beat) begin
              state_q    <= S_IDLE;
              done_q     <= 1'b1;
              done_err_q <= err_q | rbeat_err;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_AW: if (awready_m1) state_q <= S_WR;
        S_WR: begin
          if (wr_hs) begin
            if (last_beat) state_q <= S_BR;
            else           cnt_q   <= cnt_q + 8'd1;
          end
        end
        S_BR: begin
          if (bvalid_m1) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b1;
            done_err_q <= err_q | b_err;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign done        = done_q;
  assign done_err    = done_err_q;

  assign araddr_m1   = addr_q;
  assign arlen_m1    = len_q;
  assign arsize_m1   = 3'b100;
  assign arburst_m1  = burst_q;
  assign arcache_m1  = 4'b0011;
  assign arprot_m1   = 3'b000;
  assign arid_m1     = AXI_ID;
  assign arvalid_m1  = (state_q == S_AR);

  assign awaddr_m1   = addr_q;
  assign awlen_m1    = len_q;
  assign awsize_m1   = 3'b100;
  assign awburst_m1  = burst_q;
  assign awcache_m1  = 4'b0011;
  assign awprot_m1   = 3'b000;
  assign awid_m1     = AXI_ID;
  assign awvalid_m1  = (state_q == S_AW);

  // Read path is a straight pass-through so the stream sees no added latency.
  assign rready_m1   = (state_q == S_RD) && rbeat_ready;
  assign rbeat_valid = (state_q == S_RD) && rvalid_m1;
  assign rbeat_data  = rdata_m1;
  assign rbeat_last  = (state_q == S_RD) && last_beat;

  assign wvalid_m1   = (state_q == S_WR) && wbeat_valid;
  assign wbeat_ready = (state_q == S_WR) && wready_m1;
  assign wdata_m1    = wbeat_data;
  assign wstrb_m1    = wbeat_strb;
  assign wlast_m1    = (state_q == S_WR) && last_beat;
  assign wid_m1      = AXI_ID;

  assign bready_m1   = (state_q == S_BR);

endmodule

// File: tb/tb_aqe_axi_burst_master.sv
module tb_aqe_axi_burst_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready, cmd_write, cmd_wrap;
  logic [39:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic         wbeat_valid, wbeat_ready;
  logic [127:0] wbeat_data;
  logic [15:0]  wbeat_strb;
  logic         rbeat_valid, rbeat_ready, rbeat_last;
  logic [127:0] rbeat_data;
  logic         done, done_err;
  logic [39:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen, arid, awid, wid, rid, bid;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic [3:0]   arcache, awcache;
  logic         arvalid, arready, awvalid, awready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready, rlast, rvalid, rready, bvalid, bready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aqe_axi_burst_master #(.AXI_ID(8'h00), .ADDR_W(40)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wrap(cmd_wrap),
    .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready),
    .wbeat_data(wbeat_data), .wbeat_strb(wbeat_strb),
    .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready),
    .rbeat_data(rbeat_data), .rbeat_last(rbeat_last),
    .done(done), .done_err(done_err),
    .araddr_m1(araddr), .arlen_m1(arlen), .arsize_m1(arsize), .arburst_m1(arburst),
    .arcache_m1(arcache), .arprot_m1(arprot), .arid_m1(arid),
    .arvalid_m1(arvalid), .arready_m1(arready),
    .awaddr_m1(awaddr), .awlen_m1(awlen), .awsize_m1(awsize), .awburst_m1(awburst),
    .awcache_m1(awcache), .awprot_m1(awprot), .awid_m1(awid),
    .awvalid_m1(awvalid), .awready_m1(awready),
    .wdata_m1(wdata), .wstrb_m1(wstrb), .wlast_m1(wlast), .wid_m1(wid),
    .wvalid_m1(wvalid), .wready_m1(wready),
    .rdata_m1(rdata), .rid_m1(rid), .rresp_m1(rresp), .rlast_m1(rlast),
    .rvalid_m1(rvalid), .rready_m1(rready),
    .bid_m1(bid), .bresp_m1(bresp), .bvalid_m1(bvalid), .bready_m1(bready)
  );

  typedef struct {
    logic        wr;
    logic [39:0] addr;
    logic [7:0]  len;
    logic        wrap;
    logic [1:0]  resp;
    logic [7:0]  rsp_id;
    logic        bad_last;
    logic [39:0] exp_addr;
    logic [1:0]  exp_burst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] wpat(input int i, input int k);
    return {4{32'hA500_0000 + 32'(i * 16 + k)}};
  endfunction

  function automatic logic [127:0] rpat(input int i, input int k);
    return {4{32'h5A00_0000 + 32'(i * 16 + k)}};
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_wrap = 0;
    wbeat_valid = 0; wbeat_data = '0; wbeat_strb = '0; rbeat_ready = 0;
    arready = 0; awready = 0; wready = 0;
    rdata = '0; rid = '0; rresp = '0; rlast = 0; rvalid = 0;
    bid = '0; bresp = '0; bvalid = 0;
  endtask

  // Issue the command and take the address handshake; returns in RD/WR state at a negedge.
  task automatic issue(input int i, input vec_t v);
    @(negedge clk);
    chk($sformatf("v%0d cmd_ready_idle", i), cmd_ready, 1'b1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_wrap = v.wrap;
    if (v.wr) begin
      wbeat_valid = 1; wbeat_data = wpat(i, 0); wready = 1;
    end
    @(negedge clk);
    cmd_valid = 0;
    #1;
    chk($sformatf("v%0d cmd_ready_busy", i), cmd_ready, 1'b0);
    if (!v.wr) begin
      chk($sformatf("v%0d arvalid", i), arvalid, 1'b1);
      chk($sformatf("v%0d araddr", i), araddr, v.exp_addr);
      chk($sformatf("v%0d arlen", i), arlen, v.len);
      chk($sformatf("v%0d arburst", i), arburst, v.exp_burst);
      chk($sformatf("v%0d arsize_cache_prot", i), {arsize, arcache, arprot, arid}, {3'b100, 4'b0011, 3'b000, 8'h00});
      arready = 1;
    end else begin
      chk($sformatf("v%0d awvalid", i), awvalid, 1'b1);
      chk($sformatf("v%0d awaddr", i), awaddr, v.exp_addr);
      chk($sformatf("v%0d awlen", i), awlen, v.len);
      chk($sformatf("v%0d awburst", i), awburst, v.exp_burst);
      chk($sformatf("v%0d w_before_aw", i), {wvalid, wbeat_ready}, 2'b00);
      awready = 1;
    end
    @(negedge clk);
    arready = 0; awready = 0;
    #1;
    chk($sformatf("v%0d addr_valid_dropped", i), {arvalid, awvalid}, 2'b00);
  endtask

  task automatic finish_done(input int i, input logic exp_err);
    #1;
    chk($sformatf("v%0d done", i), {done, done_err, cmd_ready}, {1'b1, exp_err, 1'b1});
    @(negedge clk);
    #1;
    chk($sformatf("v%0d done_one_cycle", i), done, 1'b0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    issue(i, v);
    if (!v.wr) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        rvalid = 1; rdata = rpat(i, k); rresp = v.resp; rid = v.rsp_id;
        rlast = (k == int'(v.len)) ^ v.bad_last; rbeat_ready = 1;
        #1;
        chk($sformatf("v%0d b%0d rbeat_valid", i, k), {rbeat_valid, rready}, 2'b11);
        chk($sformatf("v%0d b%0d rbeat_data", i, k), rbeat_data, rpat(i, k));
        chk($sformatf("v%0d b%0d rbeat_last", i, k), rbeat_last, (k == int'(v.len)));
        chk($sformatf("v%0d b%0d no_early_done", i, k), done, 1'b0);
        @(negedge clk);
      end
      rvalid = 0; rlast = 0; rbeat_ready = 0;
    end else begin
      for (int k = 0; k <= int'(v.len); k++) begin
        wbeat_valid = 1; wbeat_data = wpat(i, k);
        wbeat_strb = (k % 2 == 0) ? 16'hFFFF : 16'h00FF; wready = 1;
        #1;
        chk($sformatf("v%0d b%0d wvalid", i, k), {wvalid, wbeat_ready, bready}, 3'b110);
        chk($sformatf("v%0d b%0d wdata", i, k), wdata, wpat(i, k));
        chk($sformatf("v%0d b%0d wstrb", i, k), wstrb, (k % 2 == 0) ? 16'hFFFF : 16'h00FF);
        chk($sformatf("v%0d b%0d wlast", i, k), wlast, (k == int'(v.len)));
        @(negedge clk);
      end
      wbeat_valid = 0; wready = 0;
      #1;
      chk($sformatf("v%0d bready", i), {bready, wvalid, done}, 3'b100);
      bvalid = 1; bresp = v.resp; bid = v.rsp_id;
      @(negedge clk);
      bvalid = 0; bresp = 0; bid = 0;
    end
    finish_done(i, v.exp_err);
  endtask

  initial begin
    int k;
    int cyc;
    vec_t v;
    //          wr  addr        len   wrap resp   id     badl exp_addr    burst  err
    vecs[0] = '{1'b0, 40'h1000, 8'd3, 1'b0, 2'b00, 8'h00, 1'b0, 40'h1000, 2'b01, 1'b0};
    vecs[1] = '{1'b1, 40'h2000, 8'd1, 1'b0, 2'b00, 8'h00, 1'b0, 40'h2000, 2'b01, 1'b0};
    vecs[2] = '{1'b1, 40'h2000, 8'd1, 1'b0, 2'b10, 8'h00, 1'b0, 40'h2000, 2'b01, 1'b1};
`ifdef AQE_AXI_BURST_MASTER_WRAP_EN
    vecs[3] = '{1'b0, 40'h0030, 8'd3, 1'b1, 2'b00, 8'h00, 1'b0, 40'h0030, 2'b10, 1'b0};
`else
    vecs[3] = '{1'b0, 40'h0030, 8'd3, 1'b1, 2'b00, 8'h00, 1'b0, 40'h0030, 2'b01, 1'b0};
`endif
    vecs[4] = '{1'b0, 40'h0500, 8'd0, 1'b0, 2'b10, 8'h00, 1'b0, 40'h0500, 2'b01, 1'b1};
    vecs[5] = '{1'b0, 40'h040F, 8'd1, 1'b0, 2'b00, 8'h00, 1'b0, 40'h0400, 2'b01, 1'b0};
    vecs[6] = '{1'b1, 40'h0600, 8'd2, 1'b1, 2'b00, 8'h00, 1'b0, 40'h0600, 2'b01, 1'b0};
    vecs[7] = '{1'b0, 40'h0700, 8'd1, 1'b0, 2'b00, 8'h05, 1'b0, 40'h0700, 2'b01, 1'b1};

    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready, rbeat_valid, wbeat_ready, done, done_err}, 9'b0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_addr_len", {araddr, arlen, awaddr, awlen}, 96'h0);
    rst_n = 1;

    // Stray responses while idle must not be accepted.
    @(negedge clk);
    rvalid = 1; bvalid = 1;
    #1;
    chk("idle_stray_ready", {rready, bready, rbeat_valid}, 3'b000);
    rvalid = 0; bvalid = 0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Arready stall: arvalid and payload held for five cycles.
    v = '{1'b0, 40'h3000, 8'd1, 1'b0, 2'b00, 8'h00, 1'b1, 40'h3000, 2'b01, 1'b1};
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = v.addr; cmd_len = v.len; cmd_wrap = 0;
    @(negedge clk);
    cmd_valid = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall c%0d arvalid_addr", c), {arvalid, araddr, arlen}, {1'b1, 40'h3000, 8'd1});
      @(negedge clk);
    end
    arready = 1;
    @(negedge clk);
    arready = 0;
    // One cycle with rbeat_ready low: the beat must not be taken.
    rvalid = 1; rdata = rpat(20, 0); rlast = 1'b1; rbeat_ready = 0;
    #1;
    chk("stall rready_low", {rready, rbeat_valid, rbeat_last}, 3'b010);
    @(negedge clk);
    // rlast on beat 0 disagrees with the count: error but counter rules.
    rbeat_ready = 1;
    #1;
    chk("stall beat0_last", rbeat_last, 1'b0);
    @(negedge clk);
    rdata = rpat(20, 1); rlast = 1'b0;
    #1;
    chk("stall beat1_last", {rbeat_last, rbeat_data}, {1'b1, rpat(20, 1)});
    @(negedge clk);
    rvalid = 0; rbeat_ready = 0;
    finish_done(20, 1'b1);

    // Write with wready toggling: every beat offered until taken, exactly 4 beats.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 40'h4000; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 0; awready = 1;
    @(negedge clk);
    awready = 0;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      wbeat_valid = 1; wbeat_data = wpat(21, k); wbeat_strb = 16'hFFFF;
      wready = cyc[0];
      #1;
      chk($sformatf("toggle c%0d wvalid_data", cyc), {wvalid, wdata}, {1'b1, wpat(21, k)});
      chk($sformatf("toggle c%0d wlast", cyc), wlast, (k == 3));
      @(negedge clk);
      if (cyc[0]) k++;
      cyc++;
    end
    wbeat_valid = 0; wready = 0;
    #1;
    chk("toggle beats", k, 4);
    chk("toggle bready", {bready, wvalid}, 2'b10);
    @(negedge clk);
    #1;
    chk("toggle bready_held", {bready, done}, 2'b10);
    bvalid = 1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 0;
    finish_done(21, 1'b0);

    // Reset during a len-7 read after two beats.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 40'h5000; cmd_len = 8'd7;
    @(negedge clk);
    cmd_valid = 0; arready = 1;
    @(negedge clk);
    arready = 0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1; rdata = rpat(22, b); rlast = 0; rbeat_ready = 1;
      @(negedge clk);
    end
    rst_n = 0;
    #1;
    chk("midrst valids", {arvalid, awvalid, wvalid, rready, bready, rbeat_valid, wbeat_ready, done, done_err}, 9'b0);
    chk("midrst cmd_ready_addr", {cmd_ready, araddr, arlen}, {1'b1, 40'h0, 8'h0});
    @(negedge clk);
    rst_n = 1; rvalid = 0; rbeat_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst c%0d no_done", c), {done, cmd_ready, rready}, 3'b010);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
